// File: rtl/snek_pkg.sv
// Shared types for the snake game control path: sequencer state encoding,
// move-result codes and the bundle of phase strobes.
package snek_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DELAY = 3'd2,
        MOVE  = 3'd3,
        CHECK = 3'd4,
        SPAWN = 3'd5,
        LOSE  = 3'd6
    } msm_state_t;

    localparam logic [1:0] MV_OK      = 2'b00;
    localparam logic [1:0] MV_EAT     = 2'b01;
    localparam int         MV_DIE_BIT = 1;

    typedef struct packed {
        logic set_up;
        logic move;
        logic spawn;
        logic lose;
        logic delay;
    } msm_go_t;

    function automatic msm_go_t msm_decode(input msm_state_t s);
        msm_go_t g;
        g = '0;
        unique case (s)
            SETUP:   g.set_up = 1'b1;
            MOVE:    g.move   = 1'b1;
            SPAWN:   g.spawn  = 1'b1;
            LOSE:    g.lose   = 1'b1;
            DELAY:   g.delay  = 1'b1;
            default: g        = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/main_state_machine.sv
// Snake game sequencer: walks setup/delay/move/check/spawn/lose and strobes
// one datapath block per phase. Optional debug port under MSM_STATE_OUT_EN.
module main_state_machine
    import snek_pkg::*;
#(
    parameter bit SPAWN_ON_START = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       setUpDone,
    input  logic [1:0] movementLogic,
    input  logic       replay,
    input  logic       delayDone,
`ifdef MSM_STATE_OUT_EN
    output logic [2:0] state_dbg,
`endif
    output logic       setUpGo,
    output logic       moveGo,
    output logic       spawnGo,
    output logic       loseGo,
    output logic       delayGo
);

    msm_state_t state_q;
    msm_state_t state_d;
    msm_go_t    go_q;
    msm_go_t    go_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:  state_d = SETUP;
            SETUP: begin
                if (!setUpDone)
                    state_d = SETUP;
                else if (SPAWN_ON_START)
                    state_d = SPAWN;
                else
                    state_d = DELAY;
            end
            DELAY: state_d = delayDone ? MOVE : DELAY;
            MOVE:  state_d = CHECK;
            CHECK: begin
                if (movementLogic[MV_DIE_BIT])
                    state_d = LOSE;
                else if (movementLogic == MV_EAT)
                    state_d = SPAWN;
                else
                    state_d = DELAY;
            end
            SPAWN: state_d = DELAY;
            LOSE:  state_d = replay ? SETUP : LOSE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they track state_q exactly.
    always_comb begin
        go_d = msm_decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            go_q    <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
        end
    end

    assign setUpGo = go_q.set_up;
    assign moveGo  = go_q.move;
    assign spawnGo = go_q.spawn;
    assign loseGo  = go_q.lose;
    assign delayGo = go_q.delay;

`ifdef MSM_STATE_OUT_EN
    assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_main_state_machine.sv
// Directed bench for main_state_machine: walks every phase and checks the
// go strobes after each clock. Covers the debug port under MSM_STATE_OUT_EN.
module tb_main_state_machine;
    import snek_pkg::*;

    logic       clk;
    logic       reset;
    logic       setUpDone;
    logic [1:0] movementLogic;
    logic       replay;
    logic       delayDone;
    logic       setUpGo;
    logic       moveGo;
    logic       spawnGo;
    logic       loseGo;
    logic       delayGo;
`ifdef MSM_STATE_OUT_EN
    logic [2:0] state_dbg;
`endif

    int checks = 0;
    int errors = 0;
    logic prev_move = 1'b0;
    logic prev_spawn = 1'b0;

    // Expected strobe patterns {setUp, move, spawn, lose, delay}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_SETUP = 5'b10000;
    localparam logic [4:0] O_MOVE  = 5'b01000;
    localparam logic [4:0] O_SPAWN = 5'b00100;
    localparam logic [4:0] O_LOSE  = 5'b00010;
    localparam logic [4:0] O_DELAY = 5'b00001;

    main_state_machine #(.SPAWN_ON_START(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .setUpDone    (setUpDone),
        .movementLogic(movementLogic),
        .replay       (replay),
        .delayDone    (delayDone),
`ifdef MSM_STATE_OUT_EN
        .state_dbg    (state_dbg),
`endif
        .setUpGo      (setUpGo),
        .moveGo       (moveGo),
        .spawnGo      (spawnGo),
        .loseGo       (loseGo),
        .delayGo      (delayGo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {setUpGo, moveGo, spawnGo, loseGo, delayGo};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

`ifdef MSM_STATE_OUT_EN
    task automatic check_state(input string tag, input logic [2:0] exp);
        checks++;
        assert (state_dbg === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, state_dbg, exp);
        end
    endtask
`endif

    // One clock, then invariants that hold on every cycle.
    task automatic step();
        logic [4:0] o;
        @(posedge clk);
        #1;
        o = outs();
        checks++;
        assert ($countones(o) <= 1) else begin
            errors++;
            $error("FAIL onehot observed %b expected at most one bit", o);
        end
        checks++;
        assert (!(moveGo && prev_move) && !(spawnGo && prev_spawn)) else begin
            errors++;
            $error("FAIL pulse_len observed move %b spawn %b expected single cycle",
                   moveGo, spawnGo);
        end
        prev_move  = moveGo;
        prev_spawn = spawnGo;
    endtask

    initial begin
        reset         = 1'b1;
        setUpDone     = 1'b0;
        movementLogic = 2'b00;
        replay        = 1'b0;
        delayDone     = 1'b0;

        // 1: reset, setup, first spawn
        step();
        step();
        reset = 1'b0;
        check("reset_idle", O_NONE);
`ifdef MSM_STATE_OUT_EN
        check_state("dbg_reset", 3'd0);
`endif
        step();
        check("setup_enter", O_SETUP);
        // flags for other states are ignored in SETUP
        delayDone = 1'b1;
        replay    = 1'b1;
        movementLogic = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            check("setup_hold", O_SETUP);
        end
        delayDone = 1'b0;
        replay    = 1'b0;
        movementLogic = 2'b00;
        setUpDone = 1'b1;
        step();
        check("first_spawn", O_SPAWN);
`ifdef MSM_STATE_OUT_EN
        check_state("dbg_spawn", 3'd5);
`endif
        setUpDone = 1'b0;
        step();
        check("spawn_to_delay", O_DELAY);

        // 2: delay 15 cycles then a plain move
        for (int i = 0; i < 15; i++) begin
            step();
            check("delay_hold", O_DELAY);
        end
        delayDone = 1'b1;
        step();
        check("move_plain", O_MOVE);
        delayDone = 1'b0;
        step();
        check("check_plain", O_NONE);
`ifdef MSM_STATE_OUT_EN
        check_state("dbg_check", 3'd4);
`endif
        step();
        check("plain_to_delay", O_DELAY);

        // 3: food eaten
        delayDone = 1'b1;
        step();
        check("move_eat", O_MOVE);
        delayDone = 1'b0;
        movementLogic = MV_EAT;
        step();
        check("check_eat", O_NONE);
        step();
        check("eat_spawn", O_SPAWN);
        step();
        check("eat_to_delay", O_DELAY);

        // 4: collision, lose, replay
        movementLogic = 2'b10;
        step();
        check("delay_ignore_ml", O_DELAY);
        delayDone = 1'b1;
        step();
        check("move_die", O_MOVE);
        delayDone = 1'b0;
        step();
        check("check_die", O_NONE);
        step();
        check("lose_enter", O_LOSE);
        for (int i = 0; i < 20; i++) begin
            step();
            check("lose_hold", O_LOSE);
        end
        replay = 1'b1;
        step();
        check("replay_setup", O_SETUP);
        replay = 1'b0;

        // back to LOSE via collision code 11
        setUpDone = 1'b1;
        step();
        check("respawn", O_SPAWN);
        setUpDone = 1'b0;
        step();
        check("respawn_delay", O_DELAY);
        delayDone = 1'b1;
        movementLogic = 2'b11;
        step();
        check("move_die11", O_MOVE);
        delayDone = 1'b0;
        step();
        check("check_die11", O_NONE);
        step();
        check("lose_again", O_LOSE);
`ifdef MSM_STATE_OUT_EN
        check_state("dbg_lose", 3'd6);
`endif

        // 5: reset wins over replay
        replay = 1'b1;
        reset  = 1'b1;
        step();
        check("reset_over_replay", O_NONE);
        reset  = 1'b0;
        replay = 1'b0;
        step();
        check("after_reset_setup", O_SETUP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
